program_counter: RTL and testbench



---
 rtl/program_counter_pkg.sv | 18 +
 rtl/program_counter_if.sv | 26 ++
 rtl/program_counter.sv | 44 ++++
 tb/tb_program_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// ============================================================================
// program_counter_pkg : PC width, PC type and reset vector shared with the
//                       instruction memory and the next-PC mux.
// Revision 1.0
// ============================================================================
`default_nettype none

package program_counter_pkg;

    localparam int PC_WIDTH = 3;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET = '0;

endpackage : program_counter_pkg

`default_nettype wire

// File: rtl/program_counter_if.sv
// ============================================================================
// program_counter_if : next-PC in / current-PC out between the next-PC mux
//                      (master) and the program counter register (slave).
// Revision 1.0
// ============================================================================
`default_nettype none

interface program_counter_if;
    import program_counter_pkg::*;

    pc_t pc;
    pc_t pc_out;

    modport master (
        output pc,
        input  pc_out
    );

    modport slave (
        input  pc,
        output pc_out
    );

endinterface : program_counter_if

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// program_counter : PC register, loads next-PC every edge, sync active-low rst.
//                   Define PC_ASSERT_EN to compile the built-in SVA checks.
// Revision 1.0
// ============================================================================
`default_nettype none

module program_counter
    import program_counter_pkg::*;
#(
    parameter pc_t RESET_VALUE = PC_RESET
) (
    input  wire logic          clk,
    input  wire logic          rst,
    program_counter_if.slave   bus
);

    // No enable or stall: the upstream mux owns increment, branch and wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.pc_out <= RESET_VALUE;
        end else begin
            bus.pc_out <= bus.pc;
        end
    end

`ifdef PC_ASSERT_EN
    // pc_out is undefined until the first reset edge, so the X check waits for it.
    logic reset_seen;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reset_seen <= 1'b1;
        end
    end

    a_reset_value : assert property (@(posedge clk) !rst |=> bus.pc_out == RESET_VALUE);
    a_load_pc     : assert property (@(posedge clk) rst  |=> bus.pc_out == $past(bus.pc));
    a_no_unknown  : assert property (@(posedge clk) reset_seen |-> !$isunknown(bus.pc_out));
`endif

endmodule : program_counter

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// tb_program_counter : vector table, corner-case sequences and a randomized
//                      run against a reference model for program_counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_program_counter;
    import program_counter_pkg::*;

    typedef struct {
        logic  r;
        pc_t   p;
        pc_t   exp;
        string name;
    } vec_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    program_counter_if bus ();

    program_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pc_out=%b", bus.pc_out);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input pc_t exp);
        tests_run++;
        if (bus.pc_out !== exp) begin
            tests_failed++;
            $display("FAIL %s: pc_out=%b expected %b", name, bus.pc_out, exp);
        end
    endtask

    // Inputs change 1 ns after the posedge, well away from the sampling edge.
    task automatic apply(input logic r, input pc_t p);
        rst    = r;
        bus.pc = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[9];
        pc_t  model_pc;
        pc_t  p;
        logic r;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{r: 1'b0, p: 3'bxxx, exp: 3'b000, name: "reset_with_x"};
        vecs[1] = '{r: 1'b1, p: 3'b001, exp: 3'b001, name: "load_001"};
        vecs[2] = '{r: 1'b1, p: 3'b010, exp: 3'b010, name: "load_010"};
        vecs[3] = '{r: 1'b1, p: 3'b100, exp: 3'b100, name: "load_100"};
        vecs[4] = '{r: 1'b1, p: 3'b111, exp: 3'b111, name: "max_111"};
        vecs[5] = '{r: 1'b1, p: 3'b000, exp: 3'b000, name: "after_max_000"};
        vecs[6] = '{r: 1'b1, p: 3'b101, exp: 3'b101, name: "load_101"};
        vecs[7] = '{r: 1'b0, p: 3'b110, exp: 3'b000, name: "reset_drops_pc"};
        vecs[8] = '{r: 1'b1, p: 3'b011, exp: 3'b011, name: "release_011"};

        rst    = 1'b0;
        bus.pc = 'x;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].r, vecs[i].p);
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset mid-operation: 111 presented alongside rst=0 must never appear.
        apply(1'b1, 3'b100);
        check("mid_pre_100", 3'b100);
        rst    = 1'b0;
        bus.pc = 3'b111;
        @(posedge clk);
        #1;
        check("mid_reset", 3'b000);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("mid_reset_hold", 3'b000);
        end
        #1;
        apply(1'b1, 3'b011);
        check("mid_release_011", 3'b011);

        // Hold/latency: a mid-cycle change on pc must wait for the next edge.
        apply(1'b1, 3'b010);
        check("hold_pre_010", 3'b010);
        bus.pc = 3'b110;
        #3;
        check("hold_mid_cycle", 3'b010);
        @(posedge clk);
        #1;
        check("hold_after_edge", 3'b110);

        // Randomized run against the spec rule: reset loads the vector, else pc.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 7) != 0);
            p = pc_t'($urandom_range(0, 7));
            model_pc = r ? p : PC_RESET;
            apply(r, p);
            check("random", model_pc);
            #3;
            check("random_stable", model_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_program_counter

`default_nettype wire
